// File: rtl/counter_seq_ctrl.sv
// rtl/counter_seq_ctrl.sv - configurable up/down counter sequencer with terminal-count strobe
module counter_seq_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [WIDTH-1:0] cfg_load,
  input  logic [WIDTH-1:0] cfg_limit,
  input  logic             cfg_dir,
  input  logic             cfg_reload,
  input  logic             start,
  input  logic             stop,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             tc_pulse,
  output logic [1:0]       state_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOADED = 2'd1,
    RUN    = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] count_nxt;
  logic [WIDTH-1:0] load_q, limit_q;
  logic             dir_q, reload_q;
  logic             cfg_fire, tc_nxt;

  assign cfg_ready = (state != RUN);
  assign cfg_fire  = cfg_valid & cfg_ready;
  assign state_o   = state;

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    tc_nxt    = 1'b0;
    case (state)
      IDLE: begin
        if (cfg_fire) begin
          state_nxt = LOADED;
          count_nxt = cfg_load;
        end
      end
      LOADED: begin
        if (cfg_fire) begin
          count_nxt = cfg_load;
        end else if (start) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        // Terminal count takes priority over a pause request.
        if (count == limit_q) begin
          tc_nxt = 1'b1;
          if (reload_q) begin
            count_nxt = load_q;
            state_nxt = stop ? LOADED : RUN;
          end else begin
            state_nxt = DONE;
          end
        end else if (stop) begin
          state_nxt = LOADED;
        end else begin
          count_nxt = dir_q ? (count - ONE) : (count + ONE);
        end
      end
      DONE: begin
        if (cfg_fire) begin
          state_nxt = LOADED;
          count_nxt = cfg_load;
        end else if (start) begin
          state_nxt = RUN;
          count_nxt = load_q;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      count    <= '0;
      busy     <= 1'b0;
      tc_pulse <= 1'b0;
      load_q   <= '0;
      limit_q  <= '0;
      dir_q    <= 1'b0;
      reload_q <= 1'b0;
    end else begin
      state    <= state_nxt;
      count    <= count_nxt;
      busy     <= (state_nxt == RUN);
      tc_pulse <= tc_nxt;
      if (cfg_fire) begin
        load_q   <= cfg_load;
        limit_q  <= cfg_limit;
        dir_q    <= cfg_dir;
        reload_q <= cfg_reload;
      end
    end
  end

endmodule
